// File: rtl/ama_riscv_reg_file_sb_pkg.sv
// rtl/ama_riscv_reg_file_sb_pkg.sv - shared constants and types for the register file slice
//
// Purpose: default geometry, the x0 index and the address/data types that the
//          register file, its scoreboard and the bench agree on.
// Ports:   none (package).
package ama_riscv_rf_pkg;

    localparam int RF_X0_ZERO       = 0;
    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_ADDR_W-1:0] rf_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/ama_riscv_reg_file_sb_if.sv
// rtl/ama_riscv_reg_file_sb_if.sv - read/write/issue bundle between pipeline and register file
//
// Purpose: groups the read ports, the writeback port, the issue (mark pending)
//          port and the scoreboard status into one interface.
// Ports:   slave  - register file side: takes addresses, writeback, issue;
//                   returns rd_data, rd_pend, pend_vec, pend_any.
//          master - pipeline side, the mirror image.
interface ama_riscv_reg_file_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_pend;
    logic                          we;
    logic [ADDR_W-1:0]             addr_d;
    logic [DATA_W-1:0]             data_d;
    logic                          iss_en;
    logic [ADDR_W-1:0]             iss_addr;
    logic [NUM_REGS-1:0]           pend_vec;
    logic                          pend_any;

    modport slave (
        input  rd_addr, we, addr_d, data_d, iss_en, iss_addr,
        output rd_data, rd_pend, pend_vec, pend_any
    );

    modport master (
        output rd_addr, we, addr_d, data_d, iss_en, iss_addr,
        input  rd_data, rd_pend, pend_vec, pend_any
    );
endinterface

// File: rtl/ama_riscv_rf_scoreboard.sv
// rtl/ama_riscv_rf_scoreboard.sv - pending-write scoreboard, one bit per architectural register
//
// Purpose: issue marks a destination pending, writeback clears it. When both
//          hit the same register in one cycle the issue wins, since it belongs
//          to a younger instruction than the retiring write. Bit 0 is never set.
// Ports:   clk, rst_n (sync, active-low), iss_en/iss_addr (mark pending),
//          we/addr_d (writeback clears), pend_vec (state out).
module ama_riscv_rf_scoreboard
    import ama_riscv_rf_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_addr,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr_d,
    output logic [NUM_REGS-1:0] pend_vec
);

    logic [NUM_REGS-1:0] pend_nxt;

    always_comb begin
        pend_nxt = pend_vec;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (iss_en && iss_addr == ADDR_W'(r)) begin
                pend_nxt[r] = 1'b1;
            end else if (we && addr_d == ADDR_W'(r)) begin
                pend_nxt[r] = 1'b0;
            end
        end
        // x0 has no writer to wait for
        pend_nxt[RF_X0_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_vec <= '0;
        end else begin
            pend_vec <= pend_nxt;
        end
    end

endmodule

// File: rtl/ama_riscv_reg_file_sb.sv
// rtl/ama_riscv_reg_file_sb.sv - integer register file with N async read ports and pending-write scoreboard
//
// Purpose: architectural register array (x0 hardwired zero), one synchronous
//          write port, NUM_RD combinational read ports with per-port hazard
//          flags, and the scoreboard used by issue/writeback.
// Config:  RF_WR_BYPASS_EN - when defined, a writeback in the current cycle is
//          forwarded to matching read ports and their rd_pend is forced low.
//          Undefined, reads see the stored value and the scoreboard only.
// Ports:   clk, rst_n (sync, active-low), bus (slave modport): rd_addr,
//          rd_data, rd_pend, we, addr_d, data_d, iss_en, iss_addr, pend_vec,
//          pend_any.
module ama_riscv_reg_file_sb
    import ama_riscv_rf_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int NUM_RD   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ama_riscv_reg_file_sb_if.slave bus
);

    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] X0 = ADDR_W'(RF_X0_ZERO);

    logic [DATA_W-1:0]             rf [NUM_REGS];
    logic [NUM_REGS-1:0]           pend_vec;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                rf[r] <= '0;
            end
        end else if (bus.we && bus.addr_d != X0) begin
            rf[bus.addr_d] <= bus.data_d;
        end
    end

    ama_riscv_rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .we       (bus.we),
        .addr_d   (bus.addr_d),
        .pend_vec (pend_vec)
    );

    always_comb begin
        rd_data = '0;
        rd_pend = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (bus.rd_addr[i] != X0) begin
                rd_data[i] = rf[bus.rd_addr[i]];
                rd_pend[i] = pend_vec[bus.rd_addr[i]];
`ifdef RF_WR_BYPASS_EN
                // The forwarded value is the result the reader was waiting on,
                // so the hazard is resolved this cycle even if a same-cycle
                // issue re-marks the register (that shows from next cycle).
                if (bus.we && bus.addr_d == bus.rd_addr[i]) begin
                    rd_data[i] = bus.data_d;
                    rd_pend[i] = 1'b0;
                end
`endif
            end
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_pend  = rd_pend;
    assign bus.pend_vec = pend_vec;
    assign bus.pend_any = |pend_vec;

endmodule

// File: tb/tb_ama_riscv_reg_file_sb.sv
// tb/tb_ama_riscv_reg_file_sb.sv - scoreboard-checked directed bench for ama_riscv_reg_file_sb
module tb_ama_riscv_reg_file_sb;
    import ama_riscv_rf_pkg::*;

`ifdef RF_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        rf_data_t    d0;
        rf_data_t    d1;
        logic [1:0]  p;
        logic        pa;
        logic [31:0] pv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic chk_valid = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    ama_riscv_reg_file_sb_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) bus ();

    ama_riscv_reg_file_sb #(
        .DATA_W   (32),
        .NUM_REGS (32),
        .NUM_RD   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Monitor: samples on the falling edge whenever stimulus flags a check.
    always @(negedge clk) begin
        if (chk_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL no_expectation: check requested with empty queue");
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (bus.rd_data[0] !== e.d0 || bus.rd_data[1] !== e.d1 ||
                    bus.rd_pend !== e.p || bus.pend_any !== e.pa ||
                    bus.pend_vec !== e.pv) begin
                    miscompares++;
                    $display("FAIL %s: got d0=%h d1=%h pend=%b any=%b vec=%h, want d0=%h d1=%h pend=%b any=%b vec=%h",
                             nm, bus.rd_data[0], bus.rd_data[1], bus.rd_pend, bus.pend_any,
                             bus.pend_vec, e.d0, e.d1, e.p, e.pa, e.pv);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk_valid = 1'b0;
    endtask

    task automatic set_rd(input rf_addr_t a0, input rf_addr_t a1);
        bus.rd_addr[0] = a0;
        bus.rd_addr[1] = a1;
    endtask

    task automatic chk(input string nm, input rf_data_t d0, input rf_data_t d1,
                       input logic [1:0] p, input logic pa, input logic [31:0] pv);
        exp_t e;
        e.d0 = d0; e.d1 = d1; e.p = p; e.pa = pa; e.pv = pv;
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_valid = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.we = 1'b0; bus.addr_d = '0; bus.data_d = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0;
        set_rd(0, 0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            set_rd(rf_addr_t'(a), rf_addr_t'(31 - a));
            chk("reset_read", 0, 0, 2'b00, 1'b0, 32'h0);
        end

        // write to x0 is dropped
        bus.we = 1'b1; bus.addr_d = 0; bus.data_d = 32'hDEADBEEF; set_rd(0, 0);
        chk("x0_write_cycle", 0, 0, 2'b00, 1'b0, 32'h0);
        bus.we = 1'b0;
        chk("x0_after", 0, 0, 2'b00, 1'b0, 32'h0);

        // issue then writeback on x5
        bus.iss_en = 1'b1; bus.iss_addr = 5; set_rd(5, 0);
        chk("iss5_cycle", 0, 0, 2'b00, 1'b0, 32'h0);
        bus.iss_en = 1'b0; set_rd(5, 5);
        chk("pend5", 0, 0, 2'b11, 1'b1, 32'h20);
        bus.we = 1'b1; bus.addr_d = 5; bus.data_d = 32'h1234; set_rd(5, 0);
        chk("wb5_cycle", BYP ? 32'h1234 : 32'h0, 0, BYP ? 2'b00 : 2'b01, 1'b1, 32'h20);
        bus.we = 1'b0; set_rd(5, 5);
        chk("wb5_after", 32'h1234, 32'h1234, 2'b00, 1'b0, 32'h0);

        // same-cycle issue and writeback on pending x7: issue wins
        bus.iss_en = 1'b1; bus.iss_addr = 7; set_rd(0, 0);
        chk("iss7_cycle", 0, 0, 2'b00, 1'b0, 32'h0);
        bus.we = 1'b1; bus.addr_d = 7; bus.data_d = 32'hA5A5A5A5; set_rd(7, 1);
        chk("iss_wb7_cycle", BYP ? 32'hA5A5A5A5 : 32'h0, 0, BYP ? 2'b00 : 2'b01, 1'b1, 32'h80);
        bus.iss_en = 1'b0; bus.we = 1'b0; set_rd(7, 7);
        chk("iss_wb7_after", 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b11, 1'b1, 32'h80);
        bus.we = 1'b1; set_rd(0, 0);
        chk("wb7_clear_cycle", 0, 0, 2'b00, 1'b1, 32'h80);
        bus.we = 1'b0; set_rd(7, 0);
        chk("wb7_clear_after", 32'hA5A5A5A5, 0, 2'b00, 1'b0, 32'h0);

        // bypass on x9 while pending
        bus.we = 1'b1; bus.addr_d = 9; bus.data_d = 32'h11111111; set_rd(0, 9);
        chk("x9_seed_cycle", 0, BYP ? 32'h11111111 : 32'h0, 2'b00, 1'b0, 32'h0);
        bus.we = 1'b0; bus.iss_en = 1'b1; bus.iss_addr = 9; set_rd(2, 9);
        chk("iss9_cycle", 0, 32'h11111111, 2'b00, 1'b0, 32'h0);
        bus.iss_en = 1'b0; bus.we = 1'b1; bus.data_d = 32'hCAFEF00D;
        chk("byp9_cycle", 0, BYP ? 32'hCAFEF00D : 32'h11111111, BYP ? 2'b00 : 2'b10, 1'b1, 32'h200);
        bus.we = 1'b0;
        chk("byp9_after", 0, 32'hCAFEF00D, 2'b00, 1'b0, 32'h0);

        // bypass with a same-cycle re-issue of x9
        bus.iss_en = 1'b1; bus.iss_addr = 9; bus.we = 1'b1; bus.data_d = 32'h0BADF00D; set_rd(0, 9);
        chk("iss_byp9_cycle", 0, BYP ? 32'h0BADF00D : 32'hCAFEF00D, 2'b00, 1'b0, 32'h0);
        bus.iss_en = 1'b0; bus.we = 1'b0;
        chk("iss_byp9_after", 0, 32'h0BADF00D, 2'b10, 1'b1, 32'h200);
        bus.we = 1'b1; set_rd(0, 0);
        chk("wb9_clear_cycle", 0, 0, 2'b00, 1'b1, 32'h200);

        // reset mid-operation with pendings on x3, x4
        bus.addr_d = 3; bus.data_d = 32'h33333333; bus.iss_en = 1'b1; bus.iss_addr = 3;
        chk("x3_seed_iss3", 0, 0, 2'b00, 1'b0, 32'h0);
        bus.we = 1'b0; bus.iss_addr = 4; set_rd(3, 4);
        chk("iss4_cycle", 32'h33333333, 0, 2'b01, 1'b1, 32'h8);
        bus.iss_en = 1'b0;
        chk("pend34", 32'h33333333, 0, 2'b11, 1'b1, 32'h18);
        rst_n = 1'b0; bus.we = 1'b1; bus.addr_d = 3; bus.data_d = 32'h77777777;
        bus.iss_en = 1'b1; bus.iss_addr = 6; set_rd(0, 0);
        tick();
        rst_n = 1'b1; bus.we = 1'b0; bus.iss_en = 1'b0; set_rd(3, 4);
        chk("post_rst_34", 0, 0, 2'b00, 1'b0, 32'h0);
        set_rd(5, 7);
        chk("post_rst_57", 0, 0, 2'b00, 1'b0, 32'h0);
        set_rd(6, 9);
        chk("post_rst_69", 0, 0, 2'b00, 1'b0, 32'h0);
        bus.we = 1'b1; bus.addr_d = 4; bus.data_d = 32'h44444444; set_rd(0, 0);
        chk("wb4_post_rst_cycle", 0, 0, 2'b00, 1'b0, 32'h0);
        bus.we = 1'b0; set_rd(4, 6);
        chk("wb4_post_rst_after", 32'h44444444, 0, 2'b00, 1'b0, 32'h0);

        tick();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ama_riscv_reg_file_sb.md
Name: ama_riscv_reg_file_sb

Overview:
- Parametrised integer register file: NUM_RD asynchronous read ports, one synchronous write port, and a pending-write scoreboard.
- Serves multi-issue and long-latency (mul/div/load-miss) pipelines.
- Issue stage marks rd pending; writeback clears it. Decode gets per-port hazard flags and optional same-cycle write bypass.
- x0 stays hardwired zero and is never pending.

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, architectural register count; power of 2, >= 2
- NUM_RD, 2, number of read ports, 1..4
- ADDR_W, $clog2(NUM_REGS), register address width; derived, do not override

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- rd_addr  in  NUM_RD x ADDR_W  read addresses, one per port
- rd_data  out  NUM_RD x DATA_W  read data, combinational from rd_addr
- rd_pend  out  NUM_RD  read port i addresses a register with an outstanding write
- we  in  1  writeback enable
- addr_d  in  ADDR_W  writeback destination
- data_d  in  DATA_W  writeback data
- iss_en  in  1  issue of an instruction that will write iss_addr later
- iss_addr  in  ADDR_W  destination being marked pending
- pend_vec  out  NUM_REGS  scoreboard state; bit 0 is always 0
- pend_any  out  1  OR of pend_vec; used by fence/drain logic

Behaviour:
- Reset (rst_n == 0 at clk edge):
  - All registers 1..NUM_REGS-1 go to 0; pend_vec goes to 0.
  - we and iss_en are ignored in that cycle.
  - After reset, rd_data = 0 for every address; rd_pend, pend_vec and pend_any = 0.
  - Reset mid-operation discards outstanding pendings; the writeback after reset still writes data but clears nothing.
- Write:
  - When we && addr_d != 0, rf[addr_d] <= data_d at the edge.
  - A write to x0 is dropped.
- Read (zero cycle latency):
  - addr == 0 returns 0.
  - Otherwise returns rf[addr], subject to bypass (see Optional Feature).
- Scoreboard, evaluated per register r at each edge:
  - set = iss_en && iss_addr == r && r != 0.
  - clr = we && addr_d == r.
  - set && clr: pend stays 1, because the new issue is younger than the retiring write.
  - set only: pend = 1.
  - clr only: pend = 0.
  - Issue to an already-pending register: stays 1. Writes are not counted; the pipeline guarantees at most one outstanding writer per register (WAW stalled upstream).
  - Writeback to a non-pending register: legal, pend stays 0.
- rd_pend[i] = pend_vec[rd_addr[i]], adjusted by bypass; rd_addr == 0 always gives 0.
- Multiple read ports on the same address return identical data and pend.

Optional Feature:
- Macro: RF_WR_BYPASS_EN.
- Defined:
  - When we && addr_d != 0 && addr_d == rd_addr[i], rd_data[i] = data_d in the same cycle.
  - rd_pend[i] is forced 0 in that case, even if pend_vec[addr_d] == 1.
  - If iss_en targets the same register in the same cycle, the bypassed data is still returned and rd_pend[i] = 0; the new pend shows from the next cycle.
- Undefined:
  - rd_data returns the stored value; the new value is visible from the next cycle.
  - rd_pend reflects pend_vec only.
  - Decode must stall one extra cycle on write/read collisions.

Decomposition:
- Shared package ama_riscv_rf_pkg holds:
  - RF_X0_ZERO index constant
  - default DATA_W/NUM_REGS
  - typedef rf_addr_t (logic [ADDR_W-1:0])
  - typedef rf_data_t
- Sub-module ama_riscv_rf_scoreboard:
  - Owns pend_vec with its set/clr priority and reset.
  - Ports: clk, rst_n, iss_en, iss_addr, we, addr_d, pend_vec.
- Top module holds:
  - register array
  - read muxes
  - bypass logic
  - rd_pend muxing
  - pend_any reduction

Test Plan:
- Reset then read all 32 addresses on both ports -> rd_data 0, rd_pend 0, pend_any 0.
- we=1, addr_d=0, data_d=0xDEADBEEF; next cycle read x0 -> 0; pend_vec[0] stays 0.
- iss_en=1, iss_addr=5; next cycle rd_addr[0]=5 -> rd_pend[0]=1, pend_any=1. Then we=1, addr_d=5, data_d=0x1234 -> pend clears next cycle and rd_data[0]=0x1234.
- Same cycle iss_en (iss_addr=7) and we (addr_d=7, data_d=0xA5A5A5A5) with pend[7]=1 -> pend[7] stays 1 and rf[7]=0xA5A5A5A5.
- Bypass: write x9=0xCAFEF00D while rd_addr[1]=9 with pend[9]=1.
  - With RF_WR_BYPASS_EN: same cycle rd_data[1]=0xCAFEF00D, rd_pend[1]=0.
  - Without it: old value and rd_pend[1]=1 that cycle, new value the next cycle.
- Set pend on x3 and x4, assert rst_n=0 for one cycle together with we to x3 -> rf[3]=0, pend_vec=0; later writeback to x4 is accepted with no pend change.
